level_stack: RTL
================

// Module: level_stack
// PURPOSE
//  Preemption controller that produces the level / writeRaEn / writeRaData inputs consumed by rf_stack.
//  Tracks the current interrupt level and keeps a LIFO of preempted {level, pc} frames.
//  On interrupt entry it raises the level and writes ReturnMarker into ra of the new bank.
//  On handler return it pops the frame and emits the pc to resume at.
// PARAMETERS
//  DataWidth     32            width of pc / ra data
//  NumLevels     8             number of priority levels (= rf_stack banks); level 0 = thread mode
//  ReturnMarker  'hFFFF_FFFF   value written to ra on entry; a jump to it signals handler return
// PORTS
//  clk          in   1                     clock
//  reset        in   1                     synchronous, active-high
//  irqReq       in   1                     pending interrupt request (level-sensitive, held by source)
//  irqLevel     in   $clog2(NumLevels)     priority of the pending request
//  pc           in   DataWidth             pc to resume at if preempted this cycle
//  retEn        in   1                     core jumped to ReturnMarker this cycle
//  irqAck       out  1                     1-cycle pulse: request taken
//  level        out  $clog2(NumLevels)     current bank select to rf_stack
//  writeRaEn    out  1                     write ra of current bank (to rf_stack)
//  writeRaData  out  DataWidth             ra value (always ReturnMarker when writeRaEn)
//  pcRestoreEn  out  1                     1-cycle pulse: redirect fetch to pcRestore
//  pcRestore    out  DataWidth             popped resume pc
//  depth        out  $clog2(NumLevels)+1   number of stacked frames
//  underflowErr out  1                     sticky: retEn with empty stack
// BEHAVIOUR
//  - Reset: state=RUN, level=0, depth=0, all pulse outputs 0, pcRestore=0, writeRaData=0, underflowErr=0.
//    Reset wins over any concurrent event; a frame in flight is discarded.
//  - FSM states RUN, ENTER, EXIT; ENTER and EXIT each last exactly one cycle, then RUN.
//  - Take condition, evaluated in RUN only: irqReq && irqLevel > level.
//    Requests at or below the current level wait; they are not latched.
//  - Take at edge N:
//    - push {level, pc}, level <= irqLevel, depth++, state <= ENTER.
//    - irqAck is registered: high during cycle N+1.
//  - ENTER cycle: writeRaEn=1, writeRaData=ReturnMarker, level already new.
//    rf_stack writes ra of the new bank at the end of ENTER.
//  - Return, evaluated in RUN, depth>0 and retEn at edge N:
//    - pop: level <= saved level, pcRestore <= saved pc, depth--, state <= EXIT.
//    - pcRestoreEn=1 during EXIT.
//  - retEn with depth==0: ignored (level stays 0), underflowErr <= 1 (cleared only by reset).
//  - Simultaneous retEn and take condition in RUN: return has priority.
//    After EXIT the still-held irqReq is re-evaluated against the restored level (tail-chain).
//  - Inputs during ENTER/EXIT: irqReq and retEn ignored.
//  - Overflow is impossible: levels are strictly increasing, so max depth = NumLevels-1.
//    A push at depth==NumLevels-1 is an assertion failure.
//  - Stack storage: NumLevels-1 entries, no reset required on data (only depth is reset).
// STRUCTURE
//  - level_pkg: state_t enum {RUN, ENTER, EXIT}, frame_t struct {level, pc}, ReturnMarker default.
//  - Sub-module level_lifo: parameterised frame LIFO, push/pop/depth, registered top-of-stack.
// TESTING
//  1. Reset, idle 3 cycles
//     -> level=0, depth=0, irqAck=writeRaEn=pcRestoreEn=0.
//  2. irqReq=1, irqLevel=2, pc='h100
//     -> next cycle irqAck=1, writeRaEn=1, writeRaData='hFFFFFFFF, level=2, depth=1.
//     -> rf_stack ra of bank 2 reads 'hFFFFFFFF afterwards.
//  3. At level 2:
//     - irqLevel=1 request -> no ack, level stays 2.
//     - irqLevel=5, pc='h200 -> level=5, depth=2.
//  4. From depth 2:
//     - retEn -> pcRestoreEn=1, pcRestore='h200, level=2.
//     - retEn again -> pcRestore='h100, level=0, depth=0.
//  5. retEn and irqReq(level 3) in same RUN cycle at level 2, depth 1 -> EXIT first (level=0).
//     Then ENTER to level 3, irqAck one cycle after EXIT.
//  6. retEn at depth 0 -> underflowErr=1, level=0, stays set until reset.
//     Assert reset during ENTER -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/level_pkg.sv
// rtl/level_pkg.sv - shared types and constants for the preemption level stack
//
// Purpose: state encoding, default sizing, frame layout and the ra return
// marker used by level_stack and level_lifo.
// Ports: none (package).

package level_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_LEVELS = 8;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] RETURN_MARKER = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        ENTER = 2'd1,
        EXIT  = 2'd2
    } state_t;

    // Plain-vector aliases of the enum so the FSM register can stay a simple logic vector.
    localparam logic [1:0] ST_RUN   = 2'(RUN);
    localparam logic [1:0] ST_ENTER = 2'(ENTER);
    localparam logic [1:0] ST_EXIT  = 2'(EXIT);

    // Frame layout for the default configuration; the top packs the same
    // {level, pc} order into a plain vector so it stays parameterisable.
    typedef struct packed {
        logic [2:0]                    level;
        logic [DEFAULT_DATA_WIDTH-1:0] pc;
    } frame_t;

    // Index width that never collapses to zero bits.
    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/level_lifo.sv
// rtl/level_lifo.sv - frame LIFO with push/pop, depth count and registered top-of-stack
//
// Purpose: holds preempted frames. The top entry is kept in its own register
// so the pop data is available straight from a flop in the pop cycle.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset (clears depth only)
//   i_push, i_data   push a frame
//   i_pop            pop the top frame (ignored when empty)
//   o_top            current top-of-stack frame (valid when o_depth != 0)
//   o_depth          number of stored frames
//   o_full           o_depth == Entries

import level_pkg::*;

module level_lifo #(
    parameter int Width   = 35,
    parameter int Entries = 7,
    parameter int DepthW  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [Width-1:0]  i_data,
    output logic [Width-1:0]  o_top,
    output logic [DepthW-1:0] o_depth,
    output logic              o_full
);

    localparam int IdxW = index_width(Entries);

    logic [Width-1:0]  r_mem [Entries];
    logic [Width-1:0]  r_top;
    logic [DepthW-1:0] r_depth;

    logic [IdxW-1:0]   w_wr_idx;
    logic [IdxW-1:0]   w_below_idx;
    logic              w_pop;

    assign w_wr_idx    = IdxW'(r_depth);
    // Entry that becomes the new top after a pop.
    assign w_below_idx = IdxW'(r_depth - DepthW'(2));
    assign w_pop       = i_pop && !i_push && (r_depth != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_depth <= '0;
        end else if (i_push) begin
            r_depth <= r_depth + DepthW'(1);
        end else if (w_pop) begin
            r_depth <= r_depth - DepthW'(1);
        end
    end

    // Frame data carries no reset; only depth decides what is valid.
    always_ff @(posedge i_clk) begin
        if (!i_reset && i_push) begin
            r_mem[w_wr_idx] <= i_data;
            r_top           <= i_data;
        end else if (!i_reset && w_pop && (r_depth > DepthW'(1))) begin
            r_top <= r_mem[w_below_idx];
        end
    end

    assign o_top   = r_top;
    assign o_depth = r_depth;
    assign o_full  = (r_depth == DepthW'(Entries));

endmodule

// File: rtl/level_stack.sv
// rtl/level_stack.sv - interrupt preemption controller driving rf_stack bank select and ra writes
//
// Purpose: tracks the current interrupt level, stacks preempted {level, pc}
// frames, writes the return marker into ra of a newly entered bank and
// restores level/pc when the handler returns through the marker.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_irqReq           pending request (level-sensitive, held by source)
//   i_irqLevel         priority of the pending request
//   i_pc               pc to resume at if preempted this cycle
//   i_retEn            core jumped to the return marker this cycle
//   o_irqAck           1-cycle pulse, request taken
//   o_level            current bank select
//   o_writeRaEn        write ra of current bank
//   o_writeRaData      ra value (return marker while o_writeRaEn)
//   o_pcRestoreEn      1-cycle pulse, redirect fetch to o_pcRestore
//   o_pcRestore        popped resume pc
//   o_depth            number of stacked frames
//   o_underflowErr     sticky, return seen with an empty stack

import level_pkg::*;

module level_stack #(
    parameter int                   DataWidth    = DEFAULT_DATA_WIDTH,
    parameter int                   NumLevels    = DEFAULT_NUM_LEVELS,
    parameter logic [DataWidth-1:0] ReturnMarker = RETURN_MARKER,
    localparam int                  LevelW       = $clog2(NumLevels),
    localparam int                  DepthW       = $clog2(NumLevels) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_irqReq,
    input  logic [LevelW-1:0]    i_irqLevel,
    input  logic [DataWidth-1:0] i_pc,
    input  logic                 i_retEn,
    output logic                 o_irqAck,
    output logic [LevelW-1:0]    o_level,
    output logic                 o_writeRaEn,
    output logic [DataWidth-1:0] o_writeRaData,
    output logic                 o_pcRestoreEn,
    output logic [DataWidth-1:0] o_pcRestore,
    output logic [DepthW-1:0]    o_depth,
    output logic                 o_underflowErr
);

    localparam int FrameW = LevelW + DataWidth;

    logic [1:0]           r_state;
    logic [LevelW-1:0]    r_level;
    logic                 r_irq_ack;
    logic                 r_wr_ra_en;
    logic [DataWidth-1:0] r_wr_ra_data;
    logic                 r_pc_restore_en;
    logic [DataWidth-1:0] r_pc_restore;
    logic                 r_underflow;

    logic                 w_in_run;
    logic                 w_take;
    logic                 w_ret;
    logic                 w_underflow;
    logic                 w_push;
    logic [FrameW-1:0]    w_push_frame;
    logic [FrameW-1:0]    w_top_frame;
    logic [DepthW-1:0]    w_depth;
    logic                 w_full;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_take      = w_in_run && i_irqReq && (i_irqLevel > r_level);
    assign w_ret       = w_in_run && i_retEn && (w_depth != '0);
    assign w_underflow = w_in_run && i_retEn && (w_depth == '0);
    // A genuine return beats a simultaneous take; the held request is
    // re-evaluated against the restored level once back in RUN.
    assign w_push      = w_take && !w_ret;

    assign w_push_frame = {r_level, i_pc};

    level_lifo #(
        .Width   (FrameW),
        .Entries (NumLevels - 1),
        .DepthW  (DepthW)
    ) u_lifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_ret),
        .i_data  (w_push_frame),
        .o_top   (w_top_frame),
        .o_depth (w_depth),
        .o_full  (w_full)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_RUN;
            r_level         <= '0;
            r_irq_ack       <= 1'b0;
            r_wr_ra_en      <= 1'b0;
            r_wr_ra_data    <= '0;
            r_pc_restore_en <= 1'b0;
            r_pc_restore    <= '0;
            r_underflow     <= 1'b0;
        end else begin
            r_irq_ack       <= 1'b0;
            r_wr_ra_en      <= 1'b0;
            r_wr_ra_data    <= '0;
            r_pc_restore_en <= 1'b0;

            case (r_state)
                ST_RUN: begin
                    if (w_ret) begin
                        r_level         <= w_top_frame[FrameW-1 -: LevelW];
                        r_pc_restore    <= w_top_frame[DataWidth-1:0];
                        r_pc_restore_en <= 1'b1;
                        r_state         <= ST_EXIT;
                    end else if (w_push) begin
                        r_level      <= i_irqLevel;
                        r_irq_ack    <= 1'b1;
                        r_wr_ra_en   <= 1'b1;
                        r_wr_ra_data <= ReturnMarker;
                        r_state      <= ST_ENTER;
                    end
                    if (w_underflow) begin
                        r_underflow <= 1'b1;
                    end
                end
                default: begin
                    // ENTER and EXIT last one cycle; inputs are ignored here.
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    // Levels only ever increase on a push, so the stack cannot overflow.
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_push) begin
            assert (!w_full);
        end
    end

    assign o_irqAck       = r_irq_ack;
    assign o_level        = r_level;
    assign o_writeRaEn    = r_wr_ra_en;
    assign o_writeRaData  = r_wr_ra_data;
    assign o_pcRestoreEn  = r_pc_restore_en;
    assign o_pcRestore    = r_pc_restore;
    assign o_depth        = w_depth;
    assign o_underflowErr = r_underflow;

endmodule
